data_ram: RTL

Data-side memory responder for `mips_cpu`. It sits on the far end of the CPU's `ram_*` port set. It accepts the CPU's chip-enable, write-enable, byte-select and address, stores data with per-byte-lane writes, and returns read data one clock later. After every reset it zero-fills its array with an internal sweep before it accepts accesses, and it flags and counts accesses that fall outside its address window.

---
 rtl/data_ram_pkg.sv | 30 +++
 rtl/data_ram_if.sv | 26 ++
 rtl/data_ram_init.sv | 56 +++++
 rtl/data_ram.sv | 118 +++++++++++
 4 files changed

// File: rtl/data_ram_pkg.sv
// Shared types and constants for the data-side RAM responder.
// Imported by the bus interface, the init sequencer and the top level.
package ram_pkg;

  localparam int unsigned RAM_LANES = 4;
  localparam int unsigned DATA_W    = 8 * RAM_LANES;
  localparam int unsigned ERR_CNT_W = 16;

  typedef enum logic {
    INIT,
    RUN
  } ram_state_e;

  // Byte-lane merge: lanes with sel set take new data, the rest keep the old word.
  function automatic logic [DATA_W-1:0] lane_merge(
    input logic [DATA_W-1:0]    old_word,
    input logic [DATA_W-1:0]    new_word,
    input logic [RAM_LANES-1:0] sel
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int unsigned b = 0; b < RAM_LANES; b++) begin
      if (sel[b]) begin
        res[8*b +: 8] = new_word[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/data_ram_if.sv
// CPU data-side ram_* bus as seen between mips_cpu (master) and data_ram (slave).
// Status outputs (ready, error pulse, error count) travel with the bus.
interface data_ram_if;
  import ram_pkg::*;

  logic                   ram_ce_i;
  logic                   ram_we_i;
  logic [RAM_LANES-1:0]   ram_sel_i;
  logic [31:0]            ram_addr_i;
  logic [DATA_W-1:0]      ram_data_i;
  logic [DATA_W-1:0]      ram_data_o;
  logic                   ready_o;
  logic                   err_o;
  logic [ERR_CNT_W-1:0]   err_cnt_o;

  modport master (
    output ram_ce_i, ram_we_i, ram_sel_i, ram_addr_i, ram_data_i,
    input  ram_data_o, ready_o, err_o, err_cnt_o
  );

  modport slave (
    input  ram_ce_i, ram_we_i, ram_sel_i, ram_addr_i, ram_data_i,
    output ram_data_o, ready_o, err_o, err_cnt_o
  );

endinterface

// File: rtl/data_ram_init.sv
// INIT/RUN sequencer: after reset sweeps every word index once, then parks in RUN.
// Drives the zero-fill write port and the ready status.
module data_ram_init
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  init_we_o,
  output logic [ADDR_WIDTH-1:0] init_idx_o,
  output logic                  ready_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  ram_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    init_we_o = 1'b0;
    ready_o   = 1'b0;
    unique case (state_q)
      INIT: begin
        init_we_o = 1'b1;
        // Counter wraps to 0 on the last index, leaving it parked at 0 in RUN.
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = RUN;
        end
      end
      RUN: begin
        ready_o = 1'b1;
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign init_idx_o = cnt_q;

endmodule

// File: rtl/data_ram.sv
// Data-side memory responder for mips_cpu: byte-lane writes, 1-cycle registered reads,
// zero-fill after reset, and flag/count of accesses outside the address window.
module data_ram
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic     clk_i,
  input  logic     rst_i,
  data_ram_if.slave bus
);

  localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
  localparam int unsigned TAG_LSB = ADDR_WIDTH + 2;

  logic [DATA_W-1:0]     mem_q [DEPTH];

  logic                  init_we;
  logic [ADDR_WIDTH-1:0] init_idx;
  logic                  ready;

  logic                  in_range;
  logic [ADDR_WIDTH-1:0] cpu_idx;
  logic                  cpu_req;
  logic                  cpu_wr;
  logic                  cpu_rd;
  logic                  bad_acc;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [DATA_W-1:0]     wr_data;

  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic [1:0]            unused_addr_lsb;

  data_ram_init #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_init (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .init_we_o  (init_we),
    .init_idx_o (init_idx),
    .ready_o    (ready)
  );

  // Window decode and request qualification; nothing is accepted until RUN.
  always_comb begin
    in_range = (bus.ram_addr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
    cpu_idx  = bus.ram_addr_i[TAG_LSB-1:2];
    cpu_req  = ready && bus.ram_ce_i;
    cpu_wr   = cpu_req &&  bus.ram_we_i && in_range;
    cpu_rd   = cpu_req && !bus.ram_we_i && in_range;
    bad_acc  = cpu_req && !in_range;
  end

  assign unused_addr_lsb = bus.ram_addr_i[1:0];

  // Single write port shared by the zero-fill sweep and the CPU.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = cpu_idx;
    wr_data = '0;
    if (!rst_i) begin
      if (init_we) begin
        wr_en   = 1'b1;
        wr_idx  = init_idx;
        wr_data = '0;
      end else if (cpu_wr) begin
        wr_en   = 1'b1;
        wr_idx  = cpu_idx;
        wr_data = lane_merge(mem_q[cpu_idx], bus.ram_data_i, bus.ram_sel_i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    rdata_d   = rdata_q;
    err_d     = bad_acc;
    err_cnt_d = err_cnt_q;
    if (cpu_rd) begin
      rdata_d = mem_q[cpu_idx];
    end
    if (bad_acc) begin
      rdata_d = '0;
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.ram_data_o = rdata_q;
  assign bus.ready_o    = ready;
  assign bus.err_o      = err_q;
  assign bus.err_cnt_o  = err_cnt_q;

endmodule
